waterfall_scroller: RTL and testbench
=====================================

Name: waterfall_scroller

Overview:
Parametrised scrolling frame-buffer controller for the waterfall display. It clears the single-port frame buffer after reset, drives video read addresses with a circular row offset, and every N frames copies one line of frequency-bin magnitudes from the bin BRAM into the buffer. Compared with the current inline state machine it adds:
- generic geometry
- a runtime scroll divider
- scroll direction
- freeze
- a gain shift with saturation
- a clear request
- correct offset wrap at V_VISIBLE-1
It sits between the video timing block, the frame-buffer RAM, and the freq BRAM written by the sdft.

Parameters:
H_VISIBLE, 320, visible pixels per line
V_VISIBLE, 240, visible lines
BINS, 320, bins copied per line; must be <= H_VISIBLE
PIX_W, 8, pixel/bin data width
X_W, 9, x coordinate width
Y_W, 8, y coordinate width
FB_ADDR_W, 17, frame-buffer address width; must satisfy 2^FB_ADDR_W >= H_VISIBLE*V_VISIBLE
BIN_ADDR_W, 9, bin BRAM address width
DIV_W, 4, scroll divider width
GAIN_W, 3, gain shift width

Ports:
clk  in  1  pixel clock
resetn  in  1  asynchronous active-low reset
x  in  X_W  video x coordinate
y  in  Y_W  video y coordinate
lower_blank  in  1  high during vertical blanking below the visible area
scroll_div  in  DIV_W  scroll occurs once every scroll_div+1 frames
scroll_down  in  1  0 = new line appears at bottom (offset increments); 1 = at top (offset decrements)
freeze  in  1  inhibits line writes and offset change
gain  in  GAIN_W  left shift applied to bin data
clear_req  in  1  single-cycle pulse; re-clears the buffer
fb_addr  out  FB_ADDR_W  frame-buffer address
fb_wdata  out  PIX_W  frame-buffer write data
fb_we  out  1  frame-buffer write enable
bin_addr  out  BIN_ADDR_W  bin BRAM read address
bin_re  out  1  bin BRAM read enable
bin_rdata  in  PIX_W  bin BRAM data, valid 1 cycle after bin_re
pix_valid  out  1  low when the current pixel output must be blanked
busy_clear  out  1  high while clearing
y_offset  out  Y_W  current first-row index, for debug

Behaviour:
- Reset values: state CLEAR; fb_addr 0; fb_we 0; fb_wdata 0; bin_addr 0; bin_re 0; y_offset 0; frame counter 0; pix_valid 0; busy_clear 1.
- CLEAR:
  - fb_we=1, fb_wdata=0, fb_addr steps 0..H_VISIBLE*V_VISIBLE-1, one address per cycle.
  - The cycle after the last address: fb_we=0, busy_clear=0, go to VIDEO.
  - Exactly H*V writes; no write to address H*V.
- VIDEO, read pipeline of 2 cycles:
  - Stage 1 registers row = y+y_offset, minus V_VISIBLE if the sum >= V_VISIBLE. Use a Y_W+1-bit sum.
  - Stage 2 registers fb_addr = row*H_VISIBLE + x (constant multiply).
  - pix_valid=0 when x<3 (2 address cycles + 1 RAM cycle), else 1.
- lower_blank rising edge seen in VIDEO:
  - If frame counter == scroll_div and freeze==0: counter cleared, go to WRITE_LINE.
  - Otherwise: counter increments (held at scroll_div when freeze==1), go to WAIT_VIDEO.
- WRITE_LINE:
  - Cycle k (k=0..BINS-1): bin_re=1, bin_addr=k.
  - Cycle k+1: fb_we=1, fb_addr=y_offset*H_VISIBLE+k, fb_wdata=min(bin_rdata<<gain, 2^PIX_W-1) (saturating).
  - Total BINS+1 cycles. Columns BINS..H_VISIBLE-1 of the line are not written.
  - The write completes even if lower_blank falls mid-line. The integration requires blanking >= BINS+2 cycles.
- End of WRITE_LINE: fb_we=0, bin_re=0, then update y_offset:
  - scroll_down=0: y_offset = (y_offset==V_VISIBLE-1) ? 0 : y_offset+1.
  - scroll_down=1: y_offset = (y_offset==0) ? V_VISIBLE-1 : y_offset-1.
  - Go to WAIT_VIDEO.
- WAIT_VIDEO: go to VIDEO when lower_blank==0.
- clear_req:
  - Accepted in VIDEO or WAIT_VIDEO: go to CLEAR from address 0; y_offset and frame counter zeroed.
  - During WRITE_LINE: latched, acted on after the line completes.
  - During CLEAR: ignored.
- Input changes: scroll_down, gain, and scroll_div are sampled only at WRITE_LINE entry and frame-counter compare. Mid-line changes take effect next line.
- Reset mid-operation: asynchronous return to reset values; no partial write is completed.

Decomposition:
- Package waterfall_pkg holds:
  - state encoding: CLEAR, VIDEO, WRITE_LINE, WAIT_VIDEO
  - default geometry constants
  - READ_LAT=2
- One sub-module, sat_shift: combinational saturating left shift, parametrised PIX_W/GAIN_W. Everything else stays in one module.

Test Plan:
- Reset with H=8,V=4 -> exactly 32 writes of 0 to addresses 0..31, busy_clear falls on the cycle after address 31.
- y_offset=3, V=4, y=2, x=5, H=8 -> fb_addr=1*8+5=13 two cycles later; pix_valid=0 for x=0..2.
- scroll_div=2, bins ramp 0..7, gain=0 -> line written on every 3rd lower_blank rise; fb_wdata=k at address y_offset*8+k; y_offset increments.
- Offset wrap: scroll_down=0 at y_offset=3 -> 0; scroll_down=1 at y_offset=0 -> 3.
- gain=2, bin_rdata=0x50 -> fb_wdata=0xFF; bin_rdata=0x20 -> 0x80.
- Control corners:
  - freeze=1 for 10 frames -> no fb_we, y_offset constant.
  - clear_req during WRITE_LINE -> line finishes, then full clear, y_offset=0.
  - resetn low mid-line -> fb_we=0 immediately.

Source files
------------

// File: rtl/waterfall_pkg.sv
// Shared definitions for the waterfall scroller: controller states,
// default display geometry and the video read-pipeline latency.
package waterfall_pkg;

  typedef enum logic [1:0] {
    CLEAR      = 2'd0,
    VIDEO      = 2'd1,
    WRITE_LINE = 2'd2,
    WAIT_VIDEO = 2'd3
  } state_t;

  localparam int DEF_H_VISIBLE  = 320;
  localparam int DEF_V_VISIBLE  = 240;
  localparam int DEF_BINS       = 320;
  localparam int DEF_PIX_W      = 8;
  localparam int DEF_X_W        = 9;
  localparam int DEF_Y_W        = 8;
  localparam int DEF_FB_ADDR_W  = 17;
  localparam int DEF_BIN_ADDR_W = 9;
  localparam int DEF_DIV_W      = 4;
  localparam int DEF_GAIN_W     = 3;

  // Two address-generation cycles ahead of the frame-buffer RAM
  localparam int READ_LAT = 2;

endpackage

// File: rtl/waterfall_scroller_sat_shift.sv
// Combinational saturating left shift used to apply display gain to
// frequency-bin magnitudes before they land in the frame buffer.
module sat_shift #(
  parameter int PIX_W  = 8,
  parameter int GAIN_W = 3
) (
  input  logic [PIX_W-1:0]  din,
  input  logic [GAIN_W-1:0] shift,
  output logic [PIX_W-1:0]  dout
);

  localparam int EXT_W = PIX_W + (1 << GAIN_W) - 1;

  logic [EXT_W-1:0] shifted;

  // Shift in a word wide enough to lose nothing, then clamp on any overflow
  always_comb begin
    shifted = EXT_W'(din) << shift;
    dout    = shifted[PIX_W-1:0];
    if (|shifted[EXT_W-1:PIX_W]) dout = '1;
  end

endmodule

// File: rtl/waterfall_scroller.sv
// Scrolling frame-buffer controller for the waterfall display: clears the
// buffer, generates video read addresses with a circular row offset and
// periodically copies one line of bin magnitudes into the buffer.
module waterfall_scroller
  import waterfall_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int BINS       = DEF_BINS,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int FB_ADDR_W  = DEF_FB_ADDR_W,
  parameter int BIN_ADDR_W = DEF_BIN_ADDR_W,
  parameter int DIV_W      = DEF_DIV_W,
  parameter int GAIN_W     = DEF_GAIN_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [X_W-1:0]        x,
  input  logic [Y_W-1:0]        y,
  input  logic                  lower_blank,
  input  logic [DIV_W-1:0]      scroll_div,
  input  logic                  scroll_down,
  input  logic                  freeze,
  input  logic [GAIN_W-1:0]     gain,
  input  logic                  clear_req,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [PIX_W-1:0]      fb_wdata,
  output logic                  fb_we,
  output logic [BIN_ADDR_W-1:0] bin_addr,
  output logic                  bin_re,
  input  logic [PIX_W-1:0]      bin_rdata,
  output logic                  pix_valid,
  output logic                  busy_clear,
  output logic [Y_W-1:0]        y_offset
);

  localparam int CLR_W = FB_ADDR_W + 1;
  localparam logic [CLR_W-1:0]      CLR_END       = CLR_W'(H_VISIBLE * V_VISIBLE);
  localparam logic [Y_W-1:0]        Y_LAST        = Y_W'(V_VISIBLE - 1);
  localparam logic [Y_W:0]          V_EXT         = (Y_W + 1)'(V_VISIBLE);
  localparam logic [FB_ADDR_W-1:0]  H_MUL         = FB_ADDR_W'(H_VISIBLE);
  localparam logic [BIN_ADDR_W-1:0] BIN_LAST      = BIN_ADDR_W'(BINS - 1);
  localparam logic [X_W-1:0]        X_FIRST_VALID = X_W'(READ_LAT + 1);

  state_t state, next_state;

  logic [CLR_W-1:0]  clr_cnt;
  logic [DIV_W-1:0]  frame_cnt;
  logic [Y_W:0]      row_sum;
  logic [Y_W:0]      row_wrap;
  logic [Y_W:0]      row_r;
  logic [X_W-1:0]    x_d1;
  logic              lb_d;
  logic              lb_rise;
  logic              scroll_hit;
  logic [GAIN_W-1:0] gain_r;
  logic              dir_r;
  logic              clear_pend;
  logic [PIX_W-1:0]  sat_data;

  sat_shift #(
    .PIX_W (PIX_W),
    .GAIN_W(GAIN_W)
  ) u_sat_shift (
    .din  (bin_rdata),
    .shift(gain_r),
    .dout (sat_data)
  );

  // Row wrap, blanking edge detect and scroll decision shared by FSM and datapath
  always_comb begin
    row_sum    = {1'b0, y} + {1'b0, y_offset};
    row_wrap   = (row_sum >= V_EXT) ? row_sum - V_EXT : row_sum;
    lb_rise    = lower_blank & ~lb_d;
    scroll_hit = (frame_cnt >= scroll_div) && !freeze;
  end

  // Controller state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= CLEAR;
    else         state <= next_state;
  end

  // Next-state selection; a clear during a line waits until the line is done
  always_comb begin
    next_state = state;
    case (state)
      CLEAR:      if (clr_cnt == CLR_END) next_state = VIDEO;
      VIDEO:      if (clear_req)          next_state = CLEAR;
                  else if (lb_rise)       next_state = scroll_hit ? WRITE_LINE : WAIT_VIDEO;
      WRITE_LINE: if (!bin_re)            next_state = (clear_pend || clear_req) ? CLEAR : WAIT_VIDEO;
      WAIT_VIDEO: if (clear_req)          next_state = CLEAR;
                  else if (!lower_blank)  next_state = VIDEO;
      default:    next_state = CLEAR;
    endcase
  end

  // Status flags and write data; bin data arrives in the same cycle as its write
  always_comb begin
    busy_clear = (state == CLEAR);
    pix_valid  = (state == VIDEO) && (x >= X_FIRST_VALID);
    fb_wdata   = '0;
    if (state == WRITE_LINE && fb_we) fb_wdata = sat_data;
  end

  // Address generation, line copy sequencing, frame counting and offset update
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fb_addr    <= '0;
      fb_we      <= 1'b0;
      bin_addr   <= '0;
      bin_re     <= 1'b0;
      y_offset   <= '0;
      frame_cnt  <= '0;
      clr_cnt    <= '0;
      row_r      <= '0;
      x_d1       <= '0;
      lb_d       <= 1'b0;
      gain_r     <= '0;
      dir_r      <= 1'b0;
      clear_pend <= 1'b0;
    end else begin
      lb_d  <= lower_blank;
      row_r <= row_wrap;
      x_d1  <= x;
      case (state)
        CLEAR: begin
          if (clr_cnt == CLR_END) begin
            fb_we <= 1'b0;
          end else begin
            fb_we   <= 1'b1;
            fb_addr <= clr_cnt[FB_ADDR_W-1:0];
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        VIDEO: begin
          fb_we   <= 1'b0;
          fb_addr <= FB_ADDR_W'(row_r) * H_MUL + FB_ADDR_W'(x_d1);
          if (lb_rise) begin
            if (scroll_hit) begin
              frame_cnt <= '0;
              bin_re    <= 1'b1;
              bin_addr  <= '0;
              gain_r    <= gain;
              dir_r     <= scroll_down;
            end else if (freeze && frame_cnt >= scroll_div) begin
              frame_cnt <= scroll_div;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        WRITE_LINE: begin
          if (clear_req) clear_pend <= 1'b1;
          fb_we <= bin_re;
          if (bin_re) begin
            fb_addr <= FB_ADDR_W'(y_offset) * H_MUL + FB_ADDR_W'(bin_addr);
            if (bin_addr == BIN_LAST) bin_re   <= 1'b0;
            else                      bin_addr <= bin_addr + 1'b1;
          end else if (!dir_r) begin
            y_offset <= (y_offset == Y_LAST) ? '0 : y_offset + 1'b1;
          end else begin
            y_offset <= (y_offset == '0) ? Y_LAST : y_offset - 1'b1;
          end
        end
        default: fb_we <= 1'b0;
      endcase
      if (next_state == CLEAR && state != CLEAR) begin
        clr_cnt    <= '0;
        y_offset   <= '0;
        frame_cnt  <= '0;
        clear_pend <= 1'b0;
        fb_we      <= 1'b0;
        bin_re     <= 1'b0;
        fb_addr    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_waterfall_scroller.sv
// Scoreboard bench for waterfall_scroller on an 8x4 display with 8 bins.
module tb_waterfall_scroller;

  localparam int H          = 8;
  localparam int V          = 4;
  localparam int BINS       = 8;
  localparam int PIX_W      = 8;
  localparam int X_W        = 4;
  localparam int Y_W        = 3;
  localparam int FB_ADDR_W  = 5;
  localparam int BIN_ADDR_W = 3;
  localparam int DIV_W      = 4;
  localparam int GAIN_W     = 3;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [PIX_W-1:0]     data;
  } wr_t;

  logic                  clk;
  logic                  resetn;
  logic [X_W-1:0]        x;
  logic [Y_W-1:0]        y;
  logic                  lower_blank;
  logic [DIV_W-1:0]      scroll_div;
  logic                  scroll_down;
  logic                  freeze;
  logic [GAIN_W-1:0]     gain;
  logic                  clear_req;
  logic [FB_ADDR_W-1:0]  fb_addr;
  logic [PIX_W-1:0]      fb_wdata;
  logic                  fb_we;
  logic [BIN_ADDR_W-1:0] bin_addr;
  logic                  bin_re;
  logic [PIX_W-1:0]      bin_rdata;
  logic                  pix_valid;
  logic                  busy_clear;
  logic [Y_W-1:0]        y_offset;

  logic [PIX_W-1:0] bin_mem  [0:BINS-1];
  logic [PIX_W-1:0] exp_line [0:BINS-1];
  wr_t exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  waterfall_scroller #(
    .H_VISIBLE(H), .V_VISIBLE(V), .BINS(BINS), .PIX_W(PIX_W), .X_W(X_W),
    .Y_W(Y_W), .FB_ADDR_W(FB_ADDR_W), .BIN_ADDR_W(BIN_ADDR_W),
    .DIV_W(DIV_W), .GAIN_W(GAIN_W)
  ) dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .lower_blank(lower_blank),
    .scroll_div(scroll_div), .scroll_down(scroll_down), .freeze(freeze),
    .gain(gain), .clear_req(clear_req), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .fb_we(fb_we), .bin_addr(bin_addr), .bin_re(bin_re), .bin_rdata(bin_rdata),
    .pix_valid(pix_valid), .busy_clear(busy_clear), .y_offset(y_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bin BRAM model: data valid one cycle after the read enable
  always @(posedge clk) begin
    if (bin_re) bin_rdata <= bin_mem[bin_addr];
  end

  // Write monitor: every frame-buffer write must match the head of the queue
  always @(negedge clk) begin : monitor
    wr_t e;
    if (resetn && fb_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL write_unexpected: got addr %0d data 0x%02h, expected no write",
                 fb_addr, fb_wdata);
      end else begin
        e = exp_q.pop_front();
        if (fb_addr !== e.addr || fb_wdata !== e.data) begin
          n_fail++;
          $display("[TB] FAIL fb_write: got addr %0d data 0x%02h, expected addr %0d data 0x%02h",
                   fb_addr, fb_wdata, e.addr, e.data);
        end
      end
    end
  end

  // Watchdog so a stuck design still ends the run
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_write(input int addr, input logic [PIX_W-1:0] data);
    wr_t w;
    w.addr = FB_ADDR_W'(addr);
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic push_clear();
    for (int i = 0; i < H * V; i++) push_write(i, 8'h00);
  endtask

  // One frame of blanking; optionally expects a line at base, then checks the offset
  task automatic applyStimulus(input bit expect_write, input int base, input int off_after);
    if (expect_write)
      for (int k = 0; k < BINS; k++) push_write(base + k, exp_line[k]);
    lower_blank = 1'b1;
    repeat (12) tick();
    lower_blank = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    checkOutput("y_offset", 32'(y_offset), 32'(off_after));
    checkOutput("writes_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic wait_clear_done();
    bit seen_busy = 1'b0;
    bit seen_done = 1'b0;
    for (int i = 0; i < 40 && !seen_busy; i++) begin
      @(negedge clk);
      if (busy_clear) seen_busy = 1'b1;
    end
    checkOutput("clear_started", 32'(seen_busy), 1);
    for (int i = 0; i < 100 && !seen_done; i++) begin
      @(negedge clk);
      if (!busy_clear) seen_done = 1'b1;
    end
    checkOutput("clear_finished", 32'(seen_done), 1);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < BINS; k++) begin
      bin_mem[k]  = PIX_W'(k);
      exp_line[k] = PIX_W'(k);
    end
  endtask

  initial begin : stimulus
    logic [PIX_W-1:0] gain_in  [0:BINS-1];
    logic [PIX_W-1:0] gain_exp [0:BINS-1];
    int rd_y [0:5];
    int rd_x [0:5];
    int rd_a [0:5];
    int rd_v [0:5];
    bit found;

    gain_in  = '{8'h50, 8'h20, 8'h00, 8'h3F, 8'h40, 8'h01, 8'hFF, 8'h10};
    gain_exp = '{8'hFF, 8'h80, 8'h00, 8'hFC, 8'hFF, 8'h04, 8'hFF, 8'h40};
    rd_y = '{2, 0, 1, 3, 2, 1};
    rd_x = '{5, 7, 0, 2, 1, 3};
    rd_a = '{13, 31, 0, 18, 9, 3};
    rd_v = '{1, 1, 0, 0, 0, 1};

    resetn = 1'b0; x = '0; y = '0; lower_blank = 1'b0; scroll_div = '0;
    scroll_down = 1'b0; freeze = 1'b0; gain = '0; clear_req = 1'b0;
    set_ramp();

    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_fb_we", 32'(fb_we), 0);
    checkOutput("rst_fb_addr", 32'(fb_addr), 0);
    checkOutput("rst_fb_wdata", 32'(fb_wdata), 0);
    checkOutput("rst_bin_re", 32'(bin_re), 0);
    checkOutput("rst_busy_clear", 32'(busy_clear), 1);
    checkOutput("rst_pix_valid", 32'(pix_valid), 0);
    checkOutput("rst_y_offset", 32'(y_offset), 0);

    push_clear();
    tick();
    resetn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (fb_we && fb_addr == 5'd31) found = 1'b1;
    end
    checkOutput("last_clear_addr_seen", 32'(found), 1);
    checkOutput("busy_at_last_addr", 32'(busy_clear), 1);
    @(negedge clk);
    checkOutput("busy_fall", 32'(busy_clear), 0);
    checkOutput("we_after_clear", 32'(fb_we), 0);
    checkOutput("clear_write_count", 32'(exp_q.size()), 0);

    $display("[TB] scroll divider 2");
    scroll_div = 4'd2;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 8, 2);
    scroll_div = 4'd0;
    applyStimulus(1, 16, 3);

    $display("[TB] read pipeline at offset 3");
    for (int i = 0; i < 6; i++) begin
      tick();
      y = Y_W'(rd_y[i]);
      x = X_W'(rd_x[i]);
      tick();
      tick();
      @(negedge clk);
      checkOutput("read_addr", 32'(fb_addr), 32'(rd_a[i]));
      checkOutput("pix_valid", 32'(pix_valid), 32'(rd_v[i]));
    end
    x = '0;
    y = '0;

    $display("[TB] offset wrap both directions");
    applyStimulus(1, 24, 0);
    scroll_down = 1'b1;
    applyStimulus(1, 0, 3);

    $display("[TB] gain 2 with saturation");
    gain = 3'd2;
    for (int k = 0; k < BINS; k++) begin
      bin_mem[k]  = gain_in[k];
      exp_line[k] = gain_exp[k];
    end
    applyStimulus(1, 24, 2);

    $display("[TB] freeze for 10 frames");
    freeze = 1'b1;
    for (int f = 0; f < 10; f++) applyStimulus(0, 0, 2);
    freeze = 1'b0;
    gain = '0;
    scroll_down = 1'b0;
    set_ramp();
    applyStimulus(1, 16, 3);

    $display("[TB] clear request during line");
    for (int k = 0; k < BINS; k++) push_write(24 + k, exp_line[k]);
    push_clear();
    lower_blank = 1'b1;
    repeat (4) tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_clear_done();
    lower_blank = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    checkOutput("offset_after_clear", 32'(y_offset), 0);
    checkOutput("line_then_clear_drained", 32'(exp_q.size()), 0);

    $display("[TB] reset in the middle of a line");
    push_write(0, 8'h00);
    push_write(1, 8'h01);
    lower_blank = 1'b1;
    repeat (4) tick();
    resetn = 1'b0;
    #1;
    checkOutput("midline_rst_we", 32'(fb_we), 0);
    checkOutput("midline_rst_bin_re", 32'(bin_re), 0);
    checkOutput("midline_rst_busy", 32'(busy_clear), 1);
    checkOutput("partial_line_writes", 32'(exp_q.size()), 0);
    lower_blank = 1'b0;
    tick();
    tick();
    push_clear();
    resetn = 1'b1;
    wait_clear_done();
    repeat (2) tick();
    checkOutput("final_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
